dif_pair_feeder: RTL and testbench

//  Upstream feeder for the shared radix-2 DIF butterfly.
//  - Accepts a stream of N complex samples per frame.
//  - Buffers the first half of the frame.
//  - Pairs sample k with sample k+N/2 and presents {x0, x1, W^k} to the butterfly.
//  - Holds each pair for exactly two cycles, aligned to the butterfly's two-phase (real, then imag) schedule.

---
 rtl/dif_pair_feeder.sv | 163 ++++++++++++++++
 tb/tb_dif_pair_feeder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dif_pair_feeder.sv
// Upstream feeder for a shared two-phase radix-2 DIF butterfly. Buffers the first half of each
// N-sample frame, then pairs sample k with sample k+N/2 and holds {x0, x1, W^k} for the two
// butterfly phase cycles (real slot, then imag slot).
//
// The twiddle ROM is built at elaboration time by a constant function, so no memory file is
// needed. W^k = exp(-j*2*pi*k/N) is rounded to nearest in Q(FRAC_BITS), as {re, im}.
module dif_pair_feeder #(
  parameter int unsigned N            = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FACTOR_WIDTH = 16,
  parameter int unsigned FRAC_BITS    = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*DATA_WIDTH-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [2*DATA_WIDTH-1:0]   bf_x0,
  output logic [2*DATA_WIDTH-1:0]   bf_x1,
  output logic [2*FACTOR_WIDTH-1:0] bf_w,
  output logic                      bf_valid,
  output logic                      bf_last,
  output logic [$clog2(N/2)-1:0]    bf_idx,
  output logic                      phase
);

  localparam int unsigned Half = N / 2;
  localparam int unsigned IdxW = $clog2(Half);
  localparam int unsigned SW   = 2 * DATA_WIDTH;
  localparam int unsigned WW   = 2 * FACTOR_WIDTH;
  localparam logic [IdxW-1:0] KLast = IdxW'(Half - 1);

  // pi in Q28; the Taylor series below works in Q28 with 64-bit intermediates.
  localparam longint PiQ28 = 64'sd843314857;

  // Builds the flat twiddle table {re, im} for k = 0 .. N/2-1 (angles in [0, pi)).
  function automatic logic [Half*WW-1:0] build_rom();
    logic [Half*WW-1:0] rom;
    longint theta, x2, s_term, c_term, s_sum, c_sum, re, im, rnd;
    rom = '0;
    rnd = 64'sd1 <<< (27 - FRAC_BITS);
    for (int k = 0; k < int'(Half); k++) begin
      theta  = (64'sd2 * PiQ28 * longint'(k)) / longint'(N);
      x2     = (theta * theta) >>> 28;
      s_term = theta;
      c_term = 64'sd1 <<< 28;
      s_sum  = s_term;
      c_sum  = c_term;
      for (int i = 0; i < 12; i++) begin
        s_term = -((s_term * x2) >>> 28) / longint'((2 * i + 2) * (2 * i + 3));
        c_term = -((c_term * x2) >>> 28) / longint'((2 * i + 1) * (2 * i + 2));
        s_sum  = s_sum + s_term;
        c_sum  = c_sum + c_term;
      end
      // Round half up into Q(FRAC_BITS); imag part is -sin for the forward transform.
      re = (c_sum + rnd) >>> (28 - FRAC_BITS);
      im = (-s_sum + rnd) >>> (28 - FRAC_BITS);
      rom[k*WW +: WW] = {FACTOR_WIDTH'(re), FACTOR_WIDTH'(im)};
    end
    return rom;
  endfunction

  localparam logic [Half*WW-1:0] Rom = build_rom();

  typedef enum logic {StFill, StPair} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     k_q, k_d;
  logic                phase_q;
  logic                in_ready_q, in_ready_d;
  logic                accept, fill_we, pair_take;
  logic [SW-1:0]       half_buf_q [Half];
  logic [SW-1:0]       bf_x0_q, bf_x1_q;
  logic [WW-1:0]       bf_w_q;
  logic                bf_valid_q, bf_last_q;
  logic [IdxW-1:0]     bf_idx_q;

  // Next-state: FILL stores the first half, PAIR consumes the second half one per phase-1 slot.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    fill_we   = 1'b0;
    pair_take = 1'b0;
    accept    = in_valid & in_ready_q;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          fill_we = 1'b1;
          if (k_q == KLast) begin
            k_d     = '0;
            state_d = StPair;
          end else begin
            k_d = k_q + IdxW'(1);
          end
        end
      end
      StPair: begin
        if (accept) begin
          pair_take = 1'b1;
          if (k_q == KLast) begin
            k_d     = '0;
            state_d = StFill;
          end else begin
            k_d = k_q + IdxW'(1);
          end
        end
      end
      default: state_d = StFill;
    endcase
    // Registered ready: in PAIR it is high only when the coming cycle is phase 1.
    in_ready_d = (state_d == StFill) | ~phase_q;
  end

  // Control state, phase counter and the registered butterfly pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFill;
      k_q        <= '0;
      phase_q    <= 1'b0;
      in_ready_q <= 1'b0;
      bf_x0_q    <= '0;
      bf_x1_q    <= '0;
      bf_w_q     <= '0;
      bf_idx_q   <= '0;
      bf_valid_q <= 1'b0;
      bf_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      phase_q    <= ~phase_q;
      in_ready_q <= in_ready_d;
      if (pair_take) begin
        bf_x0_q    <= half_buf_q[k_q];
        bf_x1_q    <= in_data;
        bf_w_q     <= Rom[k_q*WW +: WW];
        bf_idx_q   <= k_q;
        bf_last_q  <= (k_q == KLast);
        bf_valid_q <= 1'b1;
      end else if (phase_q) begin
        // A pair lives for one phase-0 and one phase-1 cycle; drop it at the phase-1 edge.
        bf_valid_q <= 1'b0;
        bf_last_q  <= 1'b0;
      end
    end
  end

  // First-half sample buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      half_buf_q[k_q] <= in_data;
    end
  end

  assign in_ready = in_ready_q;
  assign bf_x0    = bf_x0_q;
  assign bf_x1    = bf_x1_q;
  assign bf_w     = bf_w_q;
  assign bf_valid = bf_valid_q;
  assign bf_last  = bf_last_q;
  assign bf_idx   = bf_idx_q;
  assign phase    = phase_q;

endmodule

// File: tb/tb_dif_pair_feeder.sv
// Scoreboard bench for dif_pair_feeder (N=8): the driver pushes expected pairs as samples are
// accepted; an independent monitor checks every butterfly window, idle hold and reset state.
module tb_dif_pair_feeder;

  localparam int N    = 8;
  localparam int Half = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] bf_x0, bf_x1;
  logic [31:0] bf_w;
  logic        bf_valid, bf_last, phase;
  logic [1:0]  bf_idx;

  dif_pair_feeder #(
    .N           (N),
    .DATA_WIDTH  (32),
    .FACTOR_WIDTH(16),
    .FRAC_BITS   (14)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .bf_x0   (bf_x0),
    .bf_x1   (bf_x1),
    .bf_w    (bf_w),
    .bf_valid(bf_valid),
    .bf_last (bf_last),
    .bf_idx  (bf_idx),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [31:0] w;
    logic [1:0]  idx;
    logic        last;
  } pair_t;

  pair_t exp_q[$];
  int    checks = 0;
  int    fails  = 0;
  int    cyc    = 0;

  // Hand-computed Q14 twiddles: 16384+j0, 11585-j11585, 0-j16384, -11585-j11585.
  logic [31:0] wtab [Half] = '{32'h4000_0000, 32'h2D41_D2BF, 32'h0000_C000, 32'hD2BF_D2BF};
  // Expected accept offsets (cycles) of x0..x7 in a frame started right after reset.
  int          gap  [N]    = '{0, 1, 2, 3, 4, 6, 8, 10};

  logic [63:0] fbuf [Half];
  int          n_in     = 0;
  int          last_acc = 0;
  int          acc [N];
  int          prev_x7;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Offer one sample until accepted, then record the pair it completes (if any).
  task automatic send(input logic [63:0] d);
    logic rdy;
    bit   done;
    done     = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
    end
    chk("accept_timeout", {63'd0, done}, 64'd1);
    last_acc = cyc;
    if (n_in < Half) begin
      fbuf[n_in] = d;
    end else begin
      exp_q.push_back('{x0: fbuf[n_in-Half], x1: d, w: wtab[n_in-Half],
                        idx: 2'(n_in - Half), last: (n_in == N - 1)});
    end
    n_in = (n_in + 1) % N;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Monitor: window start must be phase 0 and match the queue head; the second window cycle
  // must be phase 1 with identical data; idle cycles must hold data; post-reset state is zero.
  initial begin
    pair_t last_p;
    logic  rst_prev;
    logic  win_open;
    last_p   = '0;
    rst_prev = 1'b1;
    win_open = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        exp_q.delete();
        last_p   = '0;
        win_open = 1'b0;
        chk("rst_valid", {63'd0, bf_valid}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_phase", {63'd0, phase}, 64'd0);
        chk("rst_x0", bf_x0, 64'd0);
        chk("rst_x1", bf_x1, 64'd0);
        chk("rst_w_idx_last", {31'd0, bf_w, bf_idx, bf_last}, 64'd0);
      end else if (win_open) begin
        win_open = 1'b0;
        chk("win2_valid", {63'd0, bf_valid}, 64'd1);
        chk("win2_phase", {63'd0, phase}, 64'd1);
        chk("win2_x0", bf_x0, last_p.x0);
        chk("win2_x1", bf_x1, last_p.x1);
        chk("win2_w", {32'd0, bf_w}, {32'd0, last_p.w});
      end else if (bf_valid) begin
        chk("win_phase", {63'd0, phase}, 64'd0);
        if (exp_q.size() == 0) begin
          chk("valid_without_expected_pair", {63'd0, bf_valid}, 64'd0);
        end else begin
          last_p   = exp_q.pop_front();
          win_open = 1'b1;
          chk("pair_x0", bf_x0, last_p.x0);
          chk("pair_x1", bf_x1, last_p.x1);
          chk("pair_w", {32'd0, bf_w}, {32'd0, last_p.w});
          chk("pair_idx", {62'd0, bf_idx}, {62'd0, last_p.idx});
          chk("pair_last", {63'd0, bf_last}, {63'd0, last_p.last});
        end
      end else begin
        chk("idle_last", {63'd0, bf_last}, 64'd0);
        chk("idle_hold_x0", bf_x0, last_p.x0);
        chk("idle_hold_x1", bf_x1, last_p.x1);
        chk("idle_hold_w_idx", {30'd0, bf_w, bf_idx}, {30'd0, last_p.w, last_p.idx});
      end
      rst_prev = rst;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Frame A: x[n] = n + j0, in_valid held high; check the accept cadence.
    for (int i = 0; i < N; i++) begin
      send({32'(i), 32'd0});
      acc[i] = last_acc;
    end
    for (int i = 1; i < N; i++) begin
      chk($sformatf("accept_gap_x%0d", i), 64'(acc[i] - acc[0]), 64'(gap[i]));
    end
    prev_x7 = acc[N-1];

    // Frame B back-to-back: its x[0] must be taken the cycle after frame A's x[7].
    for (int i = 0; i < N; i++) begin
      send({32'(i * 1000 - 3000), 32'(-7 * i)});
      acc[i] = last_acc;
    end
    chk("back_to_back_x0", 64'(acc[0] - prev_x7), 64'd1);

    // Frame C: stall 5 cycles in PAIR after x[5].
    for (int i = 0; i < N; i++) begin
      if (i == 6) idle(5);
      send({32'h1000_0000 + 32'(i), 32'hF000_0000 - 32'(i)});
    end

    // Frame D: abort with reset after x[5].
    for (int i = 0; i < 6; i++) begin
      send({32'hABCD_0000 + 32'(i), 32'h0000_1234});
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_in = 0;

    // Frame E after reset: extreme values on pair (0,4).
    for (int i = 0; i < N; i++) begin
      if (i == 0)      send(64'h7FFF_FFFF_8000_0000);
      else if (i == 4) send(64'h8000_0000_7FFF_FFFF);
      else             send({32'(i * 3), 32'(i * 5)});
    end
    in_valid = 1'b0;

    for (int t = 0; t < 40 && exp_q.size() > 0; t++) @(posedge clk);
    repeat (4) @(posedge clk);
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
